// File: rtl/rv64_alu.sv
// rtl/rv64_alu.sv - RV64 execute-stage integer ALU with a registered result
// Eight funct3-encoded operations; c follows a, b and op by one clock.
module rv64_alu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] c
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  logic [5:0]      shamt;
  logic [XLEN-1:0] result;

  // Only the low six bits of b select the shift distance.
  assign shamt = b[5:0];

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = a + b;
      OP_SLL:  result = a << shamt;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
    end else begin
      c <= result;
    end
  end

endmodule

// File: tb/tb_rv64_alu.sv
// tb/tb_rv64_alu.sv - directed table-driven bench for rv64_alu
// Vectors carry hand-computed results; reset and streaming cases are hand-written.
module tb_rv64_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  op;
  logic [63:0] c;

  int total;
  int passed;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t pipe[$];

  rv64_alu #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;

    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd0, 64'h3_1000_0000, "seq_add"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd1, 64'h2_1000_0000, "seq_sll"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd2, 64'h0,           "seq_slt"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd3, 64'h0,           "seq_sltu"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd4, 64'h3_1000_0000, "seq_xor"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd5, 64'h2_1000_0000, "seq_srl"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd6, 64'h3_1000_0000, "seq_or"});
    vecs.push_back('{64'h2_1000_0000, 64'h1_0000_0000, 3'd7, 64'h0,           "seq_and"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 64'h0, "add_wrap"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 3'd0, 64'h8000_0000_0000_0001, "add_msb"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd0, 64'h0, "add_msb_wrap"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 3'd2, 64'h1, "slt_neg"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 3'd3, 64'h0, "sltu_big"});
    vecs.push_back('{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 3'd2, 64'h0, "slt_eq"});
    vecs.push_back('{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 3'd3, 64'h0, "sltu_eq"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd2, 64'h1, "slt_m1_0"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd3, 64'h0, "sltu_m1_0"});
    vecs.push_back('{64'h5, 64'hFFFF_FFFF_FFFF_FFFD, 3'd2, 64'h0, "slt_5_m3"});
    vecs.push_back('{64'h5, 64'hFFFF_FFFF_FFFF_FFFD, 3'd3, 64'h1, "sltu_5_big"});
    vecs.push_back('{64'h1, 64'h43, 3'd1, 64'h8, "sll_amt3"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 3'd5, 64'h1, "srl_63"});
    vecs.push_back('{64'h1, 64'd63, 3'd1, 64'h8000_0000_0000_0000, "sll_63"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 3'd5, 64'h1, "srl_63_ones"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 3'd1, 64'h8000_0000_0000_0000, "sll_63_ones"});
    vecs.push_back('{64'hA5A5_0000_1234_5678, 64'h0, 3'd1, 64'hA5A5_0000_1234_5678, "sll_zero"});
    vecs.push_back('{64'hA5A5_0000_1234_5678, 64'h40, 3'd5, 64'hA5A5_0000_1234_5678, "srl_zero_hi"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 3'd4, 64'hFEDC_BA98_7654_3210, "xor_ones"});
    vecs.push_back('{64'hF0F0_0000_FFFF_0000, 64'h0F0F_FFFF_0000_0000, 3'd6, 64'hFFFF_FFFF_FFFF_0000, "or_mix"});
    vecs.push_back('{64'hF0F0_0000_FFFF_0000, 64'hFF00_FFFF_FF00_00FF, 3'd7, 64'hF000_0000_FF00_0000, "and_mix"});

    pipe.push_back('{64'hFF, 64'h0F0F, 3'd7, 64'h0F,  "pipe_and"});
    pipe.push_back('{64'hFF, 64'h0F0F, 3'd6, 64'hFFF, "pipe_or"});
    pipe.push_back('{64'hFF, 64'h0F0F, 3'd4, 64'hFF0, "pipe_xor"});
    pipe.push_back('{64'h1234, 64'h4, 3'd1, 64'h12340, "pipe_sll"});
    pipe.push_back('{64'h1234, 64'h4, 3'd5, 64'h123,   "pipe_srl"});
    pipe.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 64'h1, "pipe_slt"});
    pipe.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 64'h1, "pipe_sltu"});
    pipe.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 64'h8000_0000_0000_0000, "pipe_add"});

    // Load a nonzero result, then assert reset between edges.
    rst_n = 1'b1;
    a     = 64'h5;
    b     = 64'h3;
    op    = 3'd0;
    @(posedge clk); #1;
    check("pre_reset_add", c, 64'h8);
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_clear", c, 64'h0);
    @(posedge clk); #1;
    check("reset_held", c, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a     = 64'h10;
    b     = 64'h20;
    op    = 3'd6;
    @(posedge clk); #1;
    check("first_after_reset", c, 64'h30);

    foreach (vecs[i]) begin
      @(negedge clk);
      a  = vecs[i].a;
      b  = vecs[i].b;
      op = vecs[i].op;
      @(posedge clk); #1;
      check(vecs[i].name, c, vecs[i].exp);
    end

    // Back-to-back: new operands right after every edge, result checked each cycle.
    foreach (pipe[i]) begin
      a  = pipe[i].a;
      b  = pipe[i].b;
      op = pipe[i].op;
      @(posedge clk); #1;
      check(pipe[i].name, c, pipe[i].exp);
    end

    // Reset mid-stream: the pending result is dropped.
    a  = 64'h1;
    b  = 64'h1;
    op = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check("midstream_reset_clear", c, 64'h0);
    @(posedge clk); #1;
    check("midstream_pending_lost", c, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midstream_resume", c, 64'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
